// File: rtl/sqrt32_pkg.sv
// Shared types and constants for the 32-bit integer square root block.
package sqrt32_pkg;

    localparam int IN_W   = 32;
    localparam int OUT_W  = 16;
    localparam int REM_W  = 18;
    localparam int N_ITER = 16;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N_ITER - 1);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sqrt32_step.sv
// One restoring digit-by-digit square-root iteration (purely combinational).
module sqrt32_step
    import sqrt32_pkg::*;
(
    input  logic [REM_W-1:0] i_rem,
    input  logic [OUT_W-1:0] i_root,
    input  logic [1:0]       i_pair,
    output logic [REM_W-1:0] o_rem,
    output logic [OUT_W-1:0] o_root
);

    logic [REM_W-1:0] w_rem_sh;
    logic [REM_W:0]   w_trial;
    logic             w_neg;
    // The top two remainder bits are always zero whenever a further iteration
    // consumes the remainder, so shifting them out loses nothing.
    logic             w_unused_rem_msbs;

    assign w_unused_rem_msbs = ^i_rem[REM_W-1:REM_W-2];

    // Bring down the next radicand pair.
    assign w_rem_sh = {i_rem[REM_W-3:0], i_pair};

    // One extra bit so the borrow shows up as a sign bit.
    assign w_trial = {1'b0, w_rem_sh} - {1'b0, i_root, 2'b01};
    assign w_neg   = w_trial[REM_W];

    // Keep the trial remainder only when the subtraction did not go negative.
    assign o_rem  = w_neg ? w_rem_sh : w_trial[REM_W-1:0];
    assign o_root = {i_root[OUT_W-2:0], ~w_neg};

endmodule

// File: rtl/sqrt32.sv
// 32-bit unsigned integer square root, one result bit per clock, free-running.
//
// state | meaning
// LOAD  | first cycle after reset: capture x, clear working registers
// CALC  | 16 iterations, one radicand pair per clock, MSB pair first
// DONE  | rdy high for this one cycle; next edge captures new x and restarts
module sqrt32
    import sqrt32_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic [IN_W-1:0]  x,
    output logic [OUT_W-1:0] y,
    output logic             rdy
);

    state_t           r_state;
    logic [IN_W-1:0]  r_x;
    logic [REM_W-1:0] r_rem;
    logic [OUT_W-1:0] r_root;
    logic [CNT_W-1:0] r_cnt;
    logic [OUT_W-1:0] r_y;
    logic             r_rdy;

    logic [REM_W-1:0] w_rem;
    logic [OUT_W-1:0] w_root;

    sqrt32_step u_step (
        .i_rem  (r_rem),
        .i_root (r_root),
        .i_pair (r_x[IN_W-1:IN_W-2]),
        .o_rem  (w_rem),
        .o_root (w_root)
    );

    // Sequencer: load, iterate 16 times, publish the root, restart.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= LOAD;
            r_x     <= '0;
            r_rem   <= '0;
            r_root  <= '0;
            r_cnt   <= '0;
            r_y     <= '0;
            r_rdy   <= 1'b0;
        end else begin
            case (r_state)
                LOAD, DONE: begin
                    r_x     <= x;
                    r_rem   <= '0;
                    r_root  <= '0;
                    r_cnt   <= '0;
                    r_rdy   <= 1'b0;
                    r_state <= CALC;
                end
                CALC: begin
                    r_x    <= {r_x[IN_W-3:0], 2'b00};
                    r_rem  <= w_rem;
                    r_root <= w_root;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == LAST_ITER) begin
                        r_y     <= w_root;
                        r_rdy   <= 1'b1;
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_rdy   <= 1'b0;
                    r_state <= LOAD;
                end
            endcase
        end
    end

    assign y   = r_y;
    assign rdy = r_rdy;

endmodule

// File: tb/tb_sqrt32.sv
// Self-checking bench for sqrt32: directed table, reset corner cases, random sweep.
module tb_sqrt32;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] x   = 32'd0;
    logic [15:0] y;
    logic        rdy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] x;
        logic [15:0] y;
    } vec_t;

    vec_t vecs [12];

    always #5 CLK = ~CLK;

    sqrt32 dut (
        .CLK (CLK),
        .RST (RST),
        .x   (x),
        .y   (y),
        .rdy (rdy)
    );

    // Reference: floor(sqrt(v)) from a real sqrt, corrected with exact integer bounds.
    function automatic longint ref_sqrt(input longint v);
        longint r;
        r = longint'($sqrt(real'(v)));
        while (r > 0 && r * r > v) r--;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge where the DUT is in LOAD or DONE; the next edge captures xv.
    // Returns the result and the number of edges until rdy (bounded).
    task automatic do_conv(input logic [31:0] xv, input logic [15:0] prev_y,
                           output logic [15:0] yv, output int lat);
        x   = xv;
        lat = 0;
        @(posedge CLK); @(negedge CLK);
        lat = 1;
        check("rdy_low_after_load", rdy, 1'b0);
        x = $urandom;
        while (!rdy && lat < 40) begin
            @(posedge CLK); @(negedge CLK);
            lat++;
            if (lat == 9) check("y_hold_mid_calc", y, prev_y);
        end
        yv = y;
    endtask

    initial begin
        logic [15:0] yv;
        logic [15:0] prev;
        int          lat;
        longint      v;
        longint      r;

        vecs[0]  = '{32'd0,          16'd0};
        vecs[1]  = '{32'd1,          16'd1};
        vecs[2]  = '{32'd24,         16'd4};
        vecs[3]  = '{32'd26,         16'd5};
        vecs[4]  = '{32'hFFFFFFFF,   16'd65535};
        vecs[5]  = '{32'hFFFE0001,   16'd65535};
        vecs[6]  = '{32'hFFFE0000,   16'd65534};
        vecs[7]  = '{32'd144,        16'd12};
        vecs[8]  = '{32'd1000000,    16'd1000};
        vecs[9]  = '{32'd15,         16'd3};
        vecs[10] = '{32'd16,         16'd4};
        vecs[11] = '{32'd2,          16'd1};

        // Reset holds outputs low while the clock runs.
        RST = 1'b0;
        x   = 32'd25;
        repeat (3) @(negedge CLK);
        check("reset_y", y, 16'd0);
        check("reset_rdy", rdy, 1'b0);

        // Release with x = 25 held: rdy on the 17th edge, y = 5.
        RST = 1'b1;
        do_conv(32'd25, 16'd0, yv, lat);
        check("first_latency", lat, 17);
        check("first_y", yv, 16'd5);
        prev = yv;

        // Directed table, back to back.
        for (int i = 0; i < 12; i++) begin
            do_conv(vecs[i].x, prev, yv, lat);
            check($sformatf("vec%0d_y", i), yv, vecs[i].y);
            check($sformatf("vec%0d_latency", i), lat, 17);
            prev = yv;
        end

        // Free-run with x = 144: result 17 clocks later, rdy one cycle wide.
        do_conv(32'd144, prev, yv, lat);
        check("freerun_144_y", yv, 16'd12);
        check("freerun_144_latency", lat, 17);
        prev = yv;

        // Abort at iteration 8 of x = 1000000.
        x = 32'd1000000;
        repeat (9) @(posedge CLK);
        @(negedge CLK);
        check("abort_pre_rdy", rdy, 1'b0);
        check("abort_pre_y_hold", y, prev);
        RST = 1'b0;
        #1;
        check("abort_y_cleared", y, 16'd0);
        check("abort_rdy_cleared", rdy, 1'b0);
        @(posedge CLK); @(negedge CLK);
        check("abort_held_y", y, 16'd0);
        check("abort_held_rdy", rdy, 1'b0);
        RST = 1'b1;
        do_conv(32'd1000000, 16'd0, yv, lat);
        check("abort_restart_y", yv, 16'd1000);
        check("abort_restart_latency", lat, 17);
        prev = yv;

        // Random sweep against the reference model.
        for (int i = 0; i < 2500; i++) begin
            case (i % 4)
                0, 1: v = longint'($urandom);
                2:    v = longint'($urandom_range(0, 65535));
                default: begin
                    r = longint'($urandom_range(0, 65535));
                    v = r * r + longint'($urandom_range(0, 2)) - 1;
                    if (v < 0) v = 0;
                end
            endcase
            do_conv(v[31:0], prev, yv, lat);
            check("rand_y", yv, ref_sqrt(v));
            check("rand_bracket",
                  ((longint'(yv) * longint'(yv) <= v) &&
                   (v < (longint'(yv) + 1) * (longint'(yv) + 1))), 1'b1);
            check("rand_latency", lat, 17);
            prev = yv;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
